// File: rtl/config_shift_engine.sv
// Serialises configuration words onto the chip's ConfigClk/ConfigIn pins, captures ConfigOut
// into readback words and strobes ConfigLoad once a full frame has been shifted.
module config_shift_engine #(
  parameter int DATA_WIDTH       = 32,
  parameter int CONFIG_REG_WIDTH = 5164,
  parameter int CLK_DIVIDER      = 100
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] rb_data,
  output logic                  rb_valid,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           stall_cnt,
  output logic                  ConfigClk,
  output logic                  ConfigIn,
  output logic                  ConfigLoad,
  input  logic                  ConfigOut
);

  // state    | meaning
  // IDLE     | waiting for start        FETCH    | waiting for the next input word
  // CLK_LOW  | ConfigClk low, bit setup CLK_HIGH | ConfigClk high, ConfigOut sampled
  // LOAD     | ConfigLoad strobe        FINISH   | one-cycle done pulse

  localparam int HALF = CLK_DIVIDER / 2;
  localparam int BW   = $clog2(CONFIG_REG_WIDTH + 1);
  localparam int DW   = $clog2(CLK_DIVIDER);
  localparam int WW   = $clog2(DATA_WIDTH);

  localparam logic [BW-1:0] LAST_BIT  = BW'(CONFIG_REG_WIDTH - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(DATA_WIDTH - 1);
  localparam logic [DW-1:0] HALF_M1   = DW'(HALF - 1);
  localparam logic [DW-1:0] LOAD_M1   = DW'(CLK_DIVIDER - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CLK_LOW,
    CLK_HIGH,
    LOAD,
    FINISH
  } state_t;

  state_t state, state_nxt;

  logic [BW-1:0]         bit_cnt;
  logic [WW-1:0]         word_bit;
  logic [DW-1:0]         div_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] rb_acc;
  logic                  div_tc;
  logic                  last_bit;
  logic                  word_end;

  assign div_tc   = (div_cnt == '0);
  assign last_bit = (bit_cnt == LAST_BIT);
  assign word_end = (word_bit == WORD_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start && !abort) state_nxt = FETCH;
      FETCH:    if (in_valid) state_nxt = CLK_LOW;
      CLK_LOW:  if (div_tc) state_nxt = CLK_HIGH;
      CLK_HIGH: if (div_tc) state_nxt = last_bit ? LOAD : (word_end ? FETCH : CLK_LOW);
      LOAD:     if (div_tc) state_nxt = FINISH;
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  // Pin-facing outputs are registered from the next state so they never glitch.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      ConfigClk  <= 1'b0;
      ConfigIn   <= 1'b0;
      ConfigLoad <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rb_valid   <= 1'b0;
      rb_data    <= '0;
      rb_acc     <= '0;
      shreg      <= '0;
      stall_cnt  <= '0;
      bit_cnt    <= '0;
      word_bit   <= '0;
      div_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      in_ready   <= (state_nxt == FETCH);
      ConfigClk  <= (state_nxt == CLK_HIGH);
      ConfigLoad <= (state_nxt == LOAD);
      busy       <= state_nxt inside {FETCH, CLK_LOW, CLK_HIGH, LOAD};
      done       <= (state_nxt == FINISH);
      rb_valid   <= 1'b0;

      if (state_nxt != state) div_cnt <= (state_nxt == LOAD) ? LOAD_M1 : HALF_M1;
      else if (!div_tc)       div_cnt <= div_cnt - 1'b1;

      case (state)
        IDLE: begin
          if (state_nxt == FETCH) begin
            bit_cnt   <= '0;
            word_bit  <= '0;
            stall_cnt <= '0;
            rb_acc    <= '0;
          end
        end
        FETCH: begin
          if (!in_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
          if (state_nxt == CLK_LOW) begin
            shreg    <= in_data;
            ConfigIn <= in_data[0];
          end
        end
        CLK_HIGH: begin
          if (div_cnt == HALF_M1) rb_acc[word_bit] <= ConfigOut;
          if (div_tc) begin
            bit_cnt  <= bit_cnt + 1'b1;
            word_bit <= word_end ? '0 : word_bit + 1'b1;
            // An aborted frame never pushes its partial readback word.
            if (state_nxt != IDLE && (word_end || last_bit)) begin
              rb_data  <= rb_acc;
              rb_valid <= 1'b1;
              rb_acc   <= '0;
            end
            if (state_nxt == CLK_LOW) begin
              shreg    <= shreg >> 1;
              ConfigIn <= shreg[1];
            end
          end
        end
        default: ;
      endcase

      if (state_nxt == LOAD || state_nxt == IDLE) ConfigIn <= 1'b0;
    end
  end

endmodule

// File: tb/tb_config_shift_engine.sv
// Randomised bench for config_shift_engine: a 40-bit frame instance and a 32-bit frame instance,
// each looped through a two-stage chip model, checked against a word-level reference model.
module tb_config_shift_engine;

  localparam int CW  = 40;
  localparam int CD  = 4;
  localparam int NW  = (CW + 31) / 32;
  localparam int CW2 = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, rb_valid, busy, done, cfg_clk, cfg_in, cfg_load;
  logic        cfg_out = 1'b0;
  logic [31:0] rb_data;
  logic [15:0] stall_cnt;

  logic        start2 = 1'b0, abort2 = 1'b0, in_valid2 = 1'b1;
  logic [31:0] in_data2 = '0;
  logic        in_ready2, rb_valid2, busy2, done2, cfg_clk2, cfg_in2, cfg_load2;
  logic        cfg_out2 = 1'b0;
  logic [31:0] rb_data2;
  logic [15:0] stall_cnt2;

  always #5 clk = ~clk;

  config_shift_engine #(.DATA_WIDTH(32), .CONFIG_REG_WIDTH(CW), .CLK_DIVIDER(CD)) u_dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rb_data(rb_data), .rb_valid(rb_valid), .busy(busy), .done(done), .stall_cnt(stall_cnt),
    .ConfigClk(cfg_clk), .ConfigIn(cfg_in), .ConfigLoad(cfg_load), .ConfigOut(cfg_out));

  config_shift_engine #(.DATA_WIDTH(32), .CONFIG_REG_WIDTH(CW2), .CLK_DIVIDER(CD)) u_dut32 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start2), .abort(abort2),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .rb_data(rb_data2), .rb_valid(rb_valid2), .busy(busy2), .done(done2), .stall_cnt(stall_cnt2),
    .ConfigClk(cfg_clk2), .ConfigIn(cfg_in2), .ConfigLoad(cfg_load2), .ConfigOut(cfg_out2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // observation state, owned by tick()
  logic        stream_q[$];
  logic [31:0] rb_q[$];
  logic [31:0] rb2_q[$];
  int          hs_cnt = 0, done_cnt = 0, load_cyc = 0, busy_cyc = 0, glitch_cnt = 0;
  int          hs2_cnt = 0, done2_cnt = 0, load2_cyc = 0, busy2_cyc = 0;
  logic [15:0] stall_at_done = '0;
  logic        clk_prev = 1'b0, clk2_prev = 1'b0, in_at_rise = 1'b0;
  logic        chip_a = 1'b0, chip_b = 1'b0, chip2_a = 1'b0, chip2_b = 1'b0;

  // word source
  logic [31:0] feed_w[2];
  int          feed_gap[2];
  int          feed_n = 0, cur = 0, gap_rem = 0;

  task automatic tick();
    bit took, stalled;
    @(negedge clk);
    took    = in_valid && in_ready;
    stalled = in_ready && !in_valid;
    if (took) hs_cnt++;
    if (rb_valid) rb_q.push_back(rb_data);
    if (done) begin
      done_cnt++;
      stall_at_done = stall_cnt;
    end
    if (cfg_load) load_cyc++;
    if (busy) busy_cyc++;
    if (cfg_clk && !clk_prev) begin
      stream_q.push_back(cfg_in);
      in_at_rise = cfg_in;
      chip_b = chip_a;
      chip_a = cfg_in;
    end else if (cfg_clk && cfg_in !== in_at_rise) glitch_cnt++;
    clk_prev = cfg_clk;
    cfg_out  = chip_b;
    if (in_valid2 && in_ready2) hs2_cnt++;
    if (rb_valid2) rb2_q.push_back(rb_data2);
    if (done2) done2_cnt++;
    if (cfg_load2) load2_cyc++;
    if (busy2) busy2_cyc++;
    if (cfg_clk2 && !clk2_prev) begin
      chip2_b = chip2_a;
      chip2_a = cfg_in2;
    end
    clk2_prev = cfg_clk2;
    cfg_out2  = chip2_b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    abort  = 1'b0;
    start2 = 1'b0;
    if (took) begin
      cur++;
      gap_rem = (cur < feed_n) ? feed_gap[cur] : 0;
    end else if (stalled && gap_rem > 0) gap_rem--;
    in_valid = (cur < feed_n) && (gap_rem == 0);
    in_data  = in_valid ? feed_w[cur] : $urandom;
  endtask

  function automatic logic sbit(input logic [31:0] a, input logic [31:0] b, input int k);
    return (k < 32) ? a[k] : b[k-32];
  endfunction

  // chip is two stages deep: after ConfigClk edge k it presents stream bit k-1
  function automatic logic [31:0] exp_rb(input logic [31:0] a, input logic [31:0] b,
                                         input logic pb, input int j);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      int k;
      k = 32 * j + i;
      if (k < CW) r[i] = (k == 0) ? pb : sbit(a, b, k - 1);
    end
    return r;
  endfunction

  task automatic setup_feed(input logic [31:0] w0, input logic [31:0] w1, input int g0, input int g1);
    feed_w[0]   = w0;
    feed_w[1]   = w1;
    feed_gap[0] = g0;
    feed_gap[1] = g1;
    feed_n      = NW;
    cur         = 0;
    gap_rem     = g0;
    in_valid    = (g0 == 0);
    in_data     = w0;
  endtask

  task automatic run_frame(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                           input int g0, input int g1, input int abort_bit, input bit extra_start);
    int          s0, r0, h0, d0, l0, b0, gl0, cyc, nb, nrb;
    logic        pb;
    logic [63:0] exp_s, obs_s;
    bit          aborted;
    setup_feed(w0, w1, g0, g1);
    s0 = stream_q.size(); r0 = rb_q.size(); h0 = hs_cnt; d0 = done_cnt;
    l0 = load_cyc; b0 = busy_cyc; gl0 = glitch_cnt;
    pb = chip_a;
    aborted = 0;
    cyc = 0;
    start = 1'b1;
    tick();
    while (done_cnt == d0 && !aborted && cyc < 3000) begin
      if (extra_start && cyc == 50) begin
        start = 1'b1;
        tick();
        cyc++;
        chk({tag, " busy through start"}, busy, 1);
      end else if (abort_bit >= 0 && stream_q.size() - s0 == abort_bit + 1 && cfg_clk) begin
        abort = 1'b1;
        tick();
        tick();
        chk({tag, " abort busy"}, busy, 0);
        chk({tag, " abort clk/in/load"}, {cfg_clk, cfg_in, cfg_load}, 0);
        aborted = 1;
      end else begin
        tick();
        cyc++;
      end
    end
    nb  = aborted ? abort_bit + 1 : CW;
    nrb = aborted ? abort_bit / 32 : NW;
    if (!aborted) begin
      chk({tag, " done"}, done_cnt - d0, 1);
      chk({tag, " stall_cnt"}, stall_at_done, g0 + g1);
      chk({tag, " busy cycles"}, busy_cyc - b0, CW * CD + CD + NW + g0 + g1);
    end
    repeat (20) tick();
    exp_s = '0;
    obs_s = '0;
    for (int k = 0; k < nb; k++) begin
      exp_s[k] = sbit(w0, w1, k);
      if (s0 + k < stream_q.size()) obs_s[k] = stream_q[s0 + k];
    end
    chk({tag, " stream len"}, stream_q.size() - s0, nb);
    chk({tag, " stream"}, obs_s, exp_s);
    chk({tag, " handshakes"}, hs_cnt - h0, aborted ? abort_bit / 32 + 1 : NW);
    chk({tag, " rb count"}, rb_q.size() - r0, nrb);
    for (int j = 0; j < nrb; j++)
      if (r0 + j < rb_q.size()) chk({tag, " rb word"}, rb_q[r0 + j], exp_rb(w0, w1, pb, j));
    chk({tag, " load cycles"}, load_cyc - l0, aborted ? 0 : CD);
    chk({tag, " done total"}, done_cnt - d0, aborted ? 0 : 1);
    chk({tag, " ConfigIn stable"}, glitch_cnt - gl0, 0);
  endtask

  initial begin
    int          cyc, h0, d0, r0, b0, l0;
    logic        pb;
    logic [31:0] w;

    repeat (2) tick();
    chk("reset held outputs", {in_ready, rb_valid, busy, done, cfg_clk, cfg_in, cfg_load}, 0);
    #3 rst_n = 1'b1;
    tick();
    chk("reset state", {in_ready, rb_valid, busy, done, cfg_clk, cfg_in, cfg_load}, 0);
    chk("reset rb_data/stall", {rb_data, stall_cnt}, 0);

    run_frame("basic", 32'h8000_0001, 32'h0000_00A5, 0, 0, -1, 0);
    run_frame("gap7", 32'h8000_0001, 32'h0000_00A5, 0, 7, -1, 0);
    run_frame("abort20", $urandom, $urandom, 0, 0, 20, 0);
    run_frame("after abort", $urandom, $urandom, 0, 0, -1, 0);
    run_frame("abort35", $urandom, $urandom, 0, 2, 35, 0);
    for (int f = 0; f < 4; f++)
      run_frame("rand", $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 5), -1, f == 1);

    // asynchronous reset in the middle of ConfigLoad
    setup_feed($urandom, $urandom, 0, 0);
    start = 1'b1;
    tick();
    cyc = 0;
    while (!cfg_load && cyc < 500) begin
      tick();
      cyc++;
    end
    chk("reach load", cfg_load, 1);
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("async reset load", cfg_load, 0);
    chk("async reset outputs", {busy, done, in_ready, rb_valid, cfg_clk, cfg_in, stall_cnt, rb_data}, 0);
    #12 rst_n = 1'b1;
    tick();
    run_frame("post reset", $urandom, $urandom, 1, 3, -1, 0);

    // start together with abort in IDLE
    h0 = hs_cnt;
    start = 1'b1;
    abort = 1'b1;
    repeat (6) tick();
    chk("start+abort idle", {busy, in_ready}, 0);
    chk("start+abort no fetch", hs_cnt - h0, 0);

    // exact word-boundary frame
    w = $urandom;
    in_data2 = w;
    pb = chip2_a;
    h0 = hs2_cnt; d0 = done2_cnt; r0 = rb2_q.size(); b0 = busy2_cyc; l0 = load2_cyc;
    start2 = 1'b1;
    tick();
    cyc = 0;
    while (done2_cnt == d0 && cyc < 1000) begin
      tick();
      cyc++;
    end
    repeat (4) tick();
    chk("w32 done", done2_cnt - d0, 1);
    chk("w32 handshakes", hs2_cnt - h0, 1);
    chk("w32 rb count", rb2_q.size() - r0, 1);
    if (rb2_q.size() > r0) chk("w32 rb word", rb2_q[r0], {w[30:0], pb});
    chk("w32 busy cycles", busy2_cyc - b0, CW2 * CD + CD + 1);
    chk("w32 load cycles", load2_cyc - l0, CD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
